// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the iterative
// AES-128 encryption sequencer and its datapath blocks.
package aes_pkg;

   localparam int NR_AES128 = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } aes_state_e;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Multiply by x in GF(2^8); the reduction keeps the result 8 bits wide.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      int idx;
      idx = (255 - int'(b)) * 8;
      return SBOX_TABLE[idx +: 8];
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one and its round constant, using four dedicated S-boxes.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] rkey,
   input  logic [7:0]   rcon,
   output logic [127:0] next_key
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_word;
   logic [31:0] temp_word;
   logic [31:0] n0, n1, n2, n3;

   // RotWord/SubWord/Rcon on the last word, then the xor chain across words.
   always_comb begin
      w0        = rkey[127:96];
      w1        = rkey[95:64];
      w2        = rkey[63:32];
      w3        = rkey[31:0];
      rot_word  = {w3[23:0], w3[31:24]};
      temp_word = {sbox(rot_word[31:24]) ^ rcon,
                   sbox(rot_word[23:16]),
                   sbox(rot_word[15:8]),
                   sbox(rot_word[7:0])};
      n0        = w0 ^ temp_word;
      n1        = w1 ^ n0;
      n2        = w2 ^ n1;
      n3        = w3 ^ n2;
      next_key  = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/mixcolumns.sv
// MixColumns: multiplies each 32-bit state column by the fixed AES matrix.
module mixcolumns
   import aes_pkg::*;
(
   input  logic [127:0] in_state,
   output logic [127:0] out_state
);

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {mul2(a0) ^ mul3(a1) ^ a2 ^ a3,
              a0 ^ mul2(a1) ^ mul3(a2) ^ a3,
              a0 ^ a1 ^ mul2(a2) ^ mul3(a3),
              mul3(a0) ^ a1 ^ a2 ^ mul2(a3)};
   endfunction

   // Column 0 occupies the top 32 bits.
   always_comb begin
      out_state = '0;
      for (int c = 0; c < 4; c++) begin
         out_state[(3 - c)*32 +: 32] = mix_column(in_state[(3 - c)*32 +: 32]);
      end
   end

endmodule

// File: rtl/shiftrows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
// State byte k sits at bits [127-8k -: 8], k = row + 4*column.
module shiftrows (
   input  logic [127:0] in_state,
   output logic [127:0] out_state
);

   // out[row][col] takes in[row][(col+row) mod 4].
   always_comb begin
      out_state = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            out_state[(15 - (r + 4*c))*8 +: 8] =
               in_state[(15 - (r + 4*((c + r) % 4)))*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/subbytes.sv
// SubBytes: substitutes all 16 state bytes through the forward S-box.
module subbytes
   import aes_pkg::*;
(
   input  logic [127:0] in_state,
   output logic [127:0] out_state
);

   // Byte-wise S-box lookup across the whole state.
   always_comb begin
      out_state = '0;
      for (int i = 0; i < 16; i++) begin
         out_state[i*8 +: 8] = sbox(in_state[i*8 +: 8]);
      end
   end

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per clock through a
// shared SubBytes/ShiftRows/MixColumns/AddRoundKey datapath, with the
// key schedule computed on the fly one step per round.
// Optional feature macro AES_ENC_STALL_EN: when defined, the ciphertext is
// held in DONE until out_ready; otherwise out_valid is a one-cycle pulse.
module aes_enc_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR           = NR_AES128,
   parameter bit RST_CLR_DATA = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_plaintext,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_ciphertext,
   output logic         busy,
   output logic [3:0]   round
);

   if (NR != NR_AES128) begin : g_bad_nr
      $error("aes_enc_round_ctrl: only NR=10 (AES-128) is supported");
   end

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   aes_state_e   fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;

   logic [127:0] sb_out;
   logic [127:0] sr_out;
   logic [127:0] mc_out;
   logic [127:0] next_key;

`ifndef AES_ENC_STALL_EN
   logic unused_out_ready;
   assign unused_out_ready = out_ready;
`endif

   subbytes u_subbytes (
      .in_state  (state_q),
      .out_state (sb_out)
   );

   shiftrows u_shiftrows (
      .in_state  (sb_out),
      .out_state (sr_out)
   );

   mixcolumns u_mixcolumns (
      .in_state  (sr_out),
      .out_state (mc_out)
   );

   aes_key_step u_key_step (
      .rkey     (rkey_q),
      .rcon     (rcon_q),
      .next_key (next_key)
   );

   // Next-state logic: accept in IDLE, one round per cycle in ROUND with the
   // MixColumns bypass on the last round, and hold the ciphertext in DONE.
   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_d = in_plaintext ^ in_key;
               rkey_d  = in_key;
               rcon_d  = RCON_INIT;
               round_d = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            rkey_d = next_key;
            if (round_q == LAST_ROUND) begin
               state_d = sr_out ^ next_key;
               fsm_d   = DONE;
            end else begin
               state_d = mc_out ^ next_key;
               rcon_d  = xtime(rcon_q);
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
`ifdef AES_ENC_STALL_EN
            if (out_ready) begin
               fsm_d   = IDLE;
               round_d = 4'd0;
            end
`else
            fsm_d   = IDLE;
            round_d = 4'd0;
`endif
         end
         default: begin
            fsm_d   = IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   // Control registers always return to IDLE/round 0 on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         rcon_q  <= RCON_INIT;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
      end
   end

   if (RST_CLR_DATA) begin : g_data_clr
      // Data registers cleared on reset so no stale ciphertext is visible.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= '0;
            rkey_q  <= '0;
         end else begin
            state_q <= state_d;
            rkey_q  <= rkey_d;
         end
      end
   end else begin : g_data_noclr
      // Data registers without reset; the FSM alone decides their meaning.
      always_ff @(posedge clk) begin
         state_q <= state_d;
         rkey_q  <= rkey_d;
      end
   end

   assign in_ready       = (fsm_q == IDLE);
   assign out_valid      = (fsm_q == DONE);
   assign busy           = (fsm_q != IDLE);
   assign round          = round_q;
   assign out_ciphertext = state_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Directed testbench for aes_enc_round_ctrl using FIPS-197 vectors.
module tb_aes_enc_round_ctrl;

   localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] AB_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] AB_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] AB_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk;
   logic         rst;
   logic         inValid;
   logic         inReady;
   logic [127:0] inPlaintext;
   logic [127:0] inKey;
   logic         outValid;
   logic         outReady;
   logic [127:0] outCiphertext;
   logic         busy;
   logic [3:0]   round;

   int compareCount;
   int mismatchCount;
   int edges;
   int seenValid;

   aes_enc_round_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (inValid),
      .in_ready       (inReady),
      .in_plaintext   (inPlaintext),
      .in_key         (inKey),
      .out_valid      (outValid),
      .out_ready      (outReady),
      .out_ciphertext (outCiphertext),
      .busy           (busy),
      .round          (round)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every comparison and report any mismatch on one line.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Offer one block while the controller is idle; returns just after the
   // accept edge with in_valid dropped.
   task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key);
      @(negedge clk);
      inValid     = 1'b1;
      inPlaintext = pt;
      inKey       = key;
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   // Count edges until out_valid is seen, bounded; -1 on timeout.
   task automatic waitOutput(output int nEdges);
      nEdges = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (outValid) begin
            nEdges = i;
            break;
         end
      end
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      rst           = 1'b1;
      inValid       = 1'b0;
      inPlaintext   = '0;
      inKey         = '0;
`ifdef AES_ENC_STALL_EN
      outReady      = 1'b1;
`else
      outReady      = 1'b0;
`endif

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 128'(inReady), 128'd1);
      checkOutput("rst_out_valid", 128'(outValid), 128'd0);
      checkOutput("rst_busy", 128'(busy), 128'd0);
      checkOutput("rst_round", 128'(round), 128'd0);
      checkOutput("rst_ciphertext", outCiphertext, 128'd0);
      rst = 1'b0;

      // FIPS-197 C.1 with latency and DONE-state checks.
      applyStimulus(C1_PT, C1_KEY);
      checkOutput("c1_busy", 128'(busy), 128'd1);
      checkOutput("c1_round1", 128'(round), 128'd1);
      checkOutput("c1_in_ready", 128'(inReady), 128'd0);
      waitOutput(edges);
      checkOutput("c1_latency", 128'(edges), 128'd10);
      checkOutput("c1_ciphertext", outCiphertext, C1_CT);
      checkOutput("c1_round_done", 128'(round), 128'd10);
      checkOutput("c1_busy_done", 128'(busy), 128'd1);
      @(posedge clk);
      #1;
      checkOutput("c1_pulse_end", 128'(outValid), 128'd0);
      checkOutput("c1_idle_ready", 128'(inReady), 128'd1);
      checkOutput("c1_idle_round", 128'(round), 128'd0);

      // FIPS-197 Appendix B.
      applyStimulus(AB_PT, AB_KEY);
      waitOutput(edges);
      checkOutput("ab_latency", 128'(edges), 128'd10);
      checkOutput("ab_ciphertext", outCiphertext, AB_CT);
      @(posedge clk);
      #1;

      // in_valid held high with data changing under a block in flight.
      @(negedge clk);
      inValid     = 1'b1;
      inPlaintext = C1_PT;
      inKey       = C1_KEY;
      @(posedge clk);
      #1;
      inPlaintext = AB_PT;
      inKey       = AB_KEY;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         inPlaintext = {$urandom, $urandom, $urandom, $urandom};
         inKey       = {$urandom, $urandom, $urandom, $urandom};
      end
      checkOutput("hold_in_ready", 128'(inReady), 128'd0);
      @(negedge clk);
      inPlaintext = AB_PT;
      inKey       = AB_KEY;
      waitOutput(edges);
      checkOutput("hold_first_ct", outCiphertext, C1_CT);
      @(posedge clk);
      #1;
      checkOutput("hold_idle_ready", 128'(inReady), 128'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("hold_second_round1", 128'(round), 128'd1);
      waitOutput(edges);
      checkOutput("hold_second_latency", 128'(edges), 128'd10);
      checkOutput("hold_second_ct", outCiphertext, AB_CT);
      @(posedge clk);
      #1;

      // Reset pulsed in the middle of round 5.
      applyStimulus(C1_PT, C1_KEY);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("mid_round5", 128'(round), 128'd5);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_in_ready", 128'(inReady), 128'd1);
      checkOutput("mid_rst_busy", 128'(busy), 128'd0);
      checkOutput("mid_rst_round", 128'(round), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      seenValid = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (outValid) seenValid++;
      end
      checkOutput("mid_no_out_valid", 128'(seenValid), 128'd0);
      applyStimulus(C1_PT, C1_KEY);
      waitOutput(edges);
      checkOutput("post_rst_latency", 128'(edges), 128'd10);
      checkOutput("post_rst_ct", outCiphertext, C1_CT);
      @(posedge clk);
      #1;

`ifdef AES_ENC_STALL_EN
      // Output held in DONE while the sink stalls.
      outReady = 1'b0;
      applyStimulus(AB_PT, AB_KEY);
      waitOutput(edges);
      checkOutput("stall_latency", 128'(edges), 128'd10);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_out_valid", 128'(outValid), 128'd1);
         checkOutput("stall_ct", outCiphertext, AB_CT);
         checkOutput("stall_in_ready", 128'(inReady), 128'd0);
      end
      @(negedge clk);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("stall_release_valid", 128'(outValid), 128'd0);
      checkOutput("stall_release_ready", 128'(inReady), 128'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
